// File: rtl/spi_shift_xfer_if.sv
// Bundle between the SD-card controller side and the SPI shift engine.
// master = controller/pad side, slave = shift engine.
interface spi_shift_xfer_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] dataSe;
    logic         MISO;
    logic         MOSI;
    logic         cs_n;
    logic         sck_en;
    logic         busy;
    logic         done;
    logic [N-1:0] dataRe;

    modport master (
        output start,
        output dataSe,
        output MISO,
        input  MOSI,
        input  cs_n,
        input  sck_en,
        input  busy,
        input  done,
        input  dataRe
    );

    modport slave (
        input  start,
        input  dataSe,
        input  MISO,
        output MOSI,
        output cs_n,
        output sck_en,
        output busy,
        output done,
        output dataRe
    );
endinterface

// File: rtl/spi_shift_xfer.sv
// Full-duplex SPI shift engine: N-bit word out on MOSI, N-bit word in
// from MISO, with chip-select / SCLK-gate timing and busy/done status.
module spi_shift_xfer #(
    parameter int N         = 8,
    parameter bit LSB_FIRST = 1'b0,
    parameter bit IDLE_MOSI = 1'b1
) (
    input logic             sclkn,
    input logic             reset,
    spi_shift_xfer_if.slave bus
);
    localparam int             CW   = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [N-1:0]  tx, tx_nx;
    logic [N-1:0]  rx, rx_nx;
    logic [N-1:0]  re, re_nx;
    logic          mosi, mosi_nx;
    logic          csn, csn_nx;
    logic          sck, sck_nx;
    logic          busy, busy_nx;
    logic          done, done_nx;

    // Bit that goes on the wire next, taken from the leading end.
    function automatic logic head(input logic [N-1:0] w);
        return LSB_FIRST ? w[0] : w[N-1];
    endfunction

    // Drop the bit just sent so the next one sits at the leading end.
    function automatic logic [N-1:0] adv(input logic [N-1:0] w);
        return LSB_FIRST ? (w >> 1) : (w << 1);
    endfunction

    // Shift a received bit in; after N shifts the first bit lands in
    // dataRe[N-1] (MSB-first) or dataRe[0] (LSB-first).
    function automatic logic [N-1:0] ins(input logic [N-1:0] w,
                                         input logic b);
        return LSB_FIRST ? {b, w[N-1:1]} : {w[N-2:0], b};
    endfunction

    // State and datapath registers; reset aborts any transfer silently.
    always_ff @(posedge sclkn or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            tx    <= '0;
            rx    <= '0;
            re    <= '0;
            mosi  <= IDLE_MOSI;
            csn   <= 1'b1;
            sck   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            tx    <= tx_nx;
            rx    <= rx_nx;
            re    <= re_nx;
            mosi  <= mosi_nx;
            csn   <= csn_nx;
            sck   <= sck_nx;
            busy  <= busy_nx;
            done  <= done_nx;
        end
    end

    // Next-state and next-output logic; start is ignored outside IDLE.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        tx_nx    = tx;
        rx_nx    = rx;
        re_nx    = re;
        mosi_nx  = mosi;
        csn_nx   = csn;
        sck_nx   = sck;
        busy_nx  = busy;
        done_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    mosi_nx  = head(bus.dataSe);
                    tx_nx    = adv(bus.dataSe);
                    csn_nx   = 1'b0;
                    sck_nx   = 1'b1;
                    busy_nx  = 1'b1;
                    cnt_nx   = '0;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                rx_nx = ins(rx, bus.MISO);
                if (cnt == LAST) begin
                    mosi_nx  = IDLE_MOSI;
                    csn_nx   = 1'b1;
                    sck_nx   = 1'b0;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                    re_nx    = ins(rx, bus.MISO);
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    mosi_nx = head(tx);
                    tx_nx   = adv(tx);
                    cnt_nx  = cnt + CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.MOSI   = mosi;
    assign bus.cs_n   = csn;
    assign bus.sck_en = sck;
    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.dataRe = re;
endmodule

// File: tb/tb_spi_shift_xfer.sv
// Self-checking bench for spi_shift_xfer: MSB/LSB 8-bit and 16-bit
// instances against a bit-list reference model.
module tb_spi_shift_xfer;
    logic        sclkn;
    logic        reset;
    logic [2:0]  start_v;
    logic [15:0] dse;
    logic        loopb;
    logic        miso_drv;
    int          sel;
    int          errors;
    int          checks;

    logic        o_mosi, o_csn, o_sck, o_busy, o_done;
    logic [15:0] o_re;

    spi_shift_xfer_if #(.N(8))  if0 ();
    spi_shift_xfer_if #(.N(8))  if1 ();
    spi_shift_xfer_if #(.N(16)) if2 ();

    assign if0.start  = start_v[0];
    assign if1.start  = start_v[1];
    assign if2.start  = start_v[2];
    assign if0.dataSe = dse[7:0];
    assign if1.dataSe = dse[7:0];
    assign if2.dataSe = dse;
    assign if0.MISO   = loopb ? if0.MOSI : miso_drv;
    assign if1.MISO   = loopb ? if1.MOSI : miso_drv;
    assign if2.MISO   = loopb ? if2.MOSI : miso_drv;

    spi_shift_xfer #(.N(8), .LSB_FIRST(1'b0), .IDLE_MOSI(1'b1)) u0 (
        .sclkn(sclkn), .reset(reset), .bus(if0)
    );
    spi_shift_xfer #(.N(8), .LSB_FIRST(1'b1), .IDLE_MOSI(1'b1)) u1 (
        .sclkn(sclkn), .reset(reset), .bus(if1)
    );
    spi_shift_xfer #(.N(16), .LSB_FIRST(1'b0), .IDLE_MOSI(1'b1)) u2 (
        .sclkn(sclkn), .reset(reset), .bus(if2)
    );

    initial begin
        sclkn = 1'b0;
        forever #5 sclkn = ~sclkn;
    end

    // Route the selected instance's outputs to common observation nets.
    always_comb begin
        o_mosi = if0.MOSI;
        o_csn  = if0.cs_n;
        o_sck  = if0.sck_en;
        o_busy = if0.busy;
        o_done = if0.done;
        o_re   = {8'h00, if0.dataRe};
        case (sel)
            1: begin
                o_mosi = if1.MOSI;
                o_csn  = if1.cs_n;
                o_sck  = if1.sck_en;
                o_busy = if1.busy;
                o_done = if1.done;
                o_re   = {8'h00, if1.dataRe};
            end
            2: begin
                o_mosi = if2.MOSI;
                o_csn  = if2.cs_n;
                o_sck  = if2.sck_en;
                o_busy = if2.busy;
                o_done = if2.done;
                o_re   = if2.dataRe;
            end
            default: ;
        endcase
    end

    // Model: i-th bit on the wire.
    function automatic logic tx_bit(input int n, input bit lsb,
                                    input logic [15:0] d, input int i);
        return lsb ? d[i] : d[n-1-i];
    endfunction

    // Model: word built from the list of received bits b[0..n-1].
    function automatic logic [15:0] pack(input int n, input bit lsb,
                                         input logic [15:0] b);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < n; i++) begin
            if (lsb) r[i] = b[i];
            else     r[n-1-i] = b[i];
        end
        return r;
    endfunction

    // One complete transfer on instance s, checked bit by bit.
    task automatic run_xfer(input int s, input logic [15:0] d,
                            input bit lp, input logic [15:0] mb,
                            input string tag);
        int          n;
        bit          lsb;
        logic [15:0] rb;
        logic [15:0] prev;
        logic [15:0] exp_re;
        logic [20:0] got;
        logic [20:0] want;
        n   = (s == 2) ? 16 : 8;
        lsb = (s == 1);
        if (n == 8) d = d & 16'h00FF;
        rb  = '0;
        sel = s;
        #1;
        prev       = o_re;
        loopb      = lp;
        dse        = d;
        start_v[s] = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(posedge sclkn);
            #1;
            start_v[s] = 1'b0;
            dse        = 16'($urandom);
            miso_drv   = mb[k];
            rb[k]      = lp ? tx_bit(n, lsb, d, k) : mb[k];
            got  = {o_mosi, o_csn, o_sck, o_busy, o_done, o_re};
            want = {tx_bit(n, lsb, d, k), 4'b0110, prev};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s bit%0d: got mosi,csn,sck,busy,done,re=%h want %h",
                         tag, k, got, want);
            end
        end
        exp_re = pack(n, lsb, rb);
        @(posedge sclkn);
        #1;
        got  = {o_mosi, o_csn, o_sck, o_busy, o_done, o_re};
        want = {5'b11001, exp_re};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s done: got mosi,csn,sck,busy,done,re=%h want %h",
                     tag, got, want);
        end
        @(posedge sclkn);
        #1;
        got  = {o_mosi, o_csn, o_sck, o_busy, o_done, o_re};
        want = {5'b11000, exp_re};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s after: got mosi,csn,sck,busy,done,re=%h want %h",
                     tag, got, want);
        end
    endtask

    task automatic test_reset();
        logic [20:0] got;
        reset = 1'b1;
        #12;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            got = {o_mosi, o_csn, o_sck, o_busy, o_done, o_re};
            checks++;
            if (got !== {5'b11000, 16'h0000}) begin
                errors++;
                $display("FAIL reset inst%0d: got %h want %h",
                         s, got, {5'b11000, 16'h0000});
            end
        end
        @(negedge sclkn);
        reset = 1'b0;
        @(posedge sclkn);
        #1;
    endtask

    task automatic test_msb_loopback();
        run_xfer(0, 16'h00C5, 1'b1, 16'h0000, "msb_c5");
        checks++;
        if (o_re !== 16'h00C5) begin
            errors++;
            $display("FAIL msb_c5 word: got %h want 00c5", o_re);
        end
        for (int i = 0; i < 3; i++)
            run_xfer(0, 16'($urandom), 1'b1, 16'h0000, "msb_rand");
    endtask

    task automatic test_lsb_loopback();
        run_xfer(1, 16'h00C5, 1'b1, 16'h0000, "lsb_c5");
        checks++;
        if (o_re !== 16'h00C5) begin
            errors++;
            $display("FAIL lsb_c5 word: got %h want 00c5", o_re);
        end
        for (int i = 0; i < 3; i++)
            run_xfer(1, 16'($urandom), 1'b1, 16'h0000, "lsb_rand");
    endtask

    task automatic test_miso();
        run_xfer(0, 16'h00FF, 1'b0, 16'h005A, "miso_fixed");
        checks++;
        if (o_re !== 16'h005A) begin
            errors++;
            $display("FAIL miso_fixed word: got %h want 005a", o_re);
        end
        for (int i = 0; i < 2; i++) begin
            run_xfer(0, 16'($urandom), 1'b0, 16'($urandom), "miso_msb");
            run_xfer(1, 16'($urandom), 1'b0, 16'($urandom), "miso_lsb");
        end
    endtask

    task automatic test_start_busy();
        logic [20:0] got;
        sel        = 0;
        loopb      = 1'b1;
        dse        = 16'h0096;
        start_v[0] = 1'b1;
        @(posedge sclkn);
        #1;
        start_v[0] = 1'b0;
        repeat (2) @(posedge sclkn);
        #1;
        start_v[0] = 1'b1;
        dse        = 16'h0000;
        @(posedge sclkn);
        #1;
        start_v[0] = 1'b0;
        repeat (4) @(posedge sclkn);
        #1;
        start_v[0] = 1'b1;
        @(posedge sclkn);
        #1;
        got = {o_mosi, o_csn, o_sck, o_busy, o_done, o_re};
        checks++;
        if (got !== {5'b11001, 16'h0096}) begin
            errors++;
            $display("FAIL busy_start E8: got %h want %h",
                     got, {5'b11001, 16'h0096});
        end
        dse = 16'h003C;
        @(posedge sclkn);
        #1;
        start_v[0] = 1'b0;
        got = {o_mosi, o_csn, o_sck, o_busy, o_done, o_re};
        checks++;
        if (got !== {5'b00110, 16'h0096}) begin
            errors++;
            $display("FAIL busy_start E9: got %h want %h",
                     got, {5'b00110, 16'h0096});
        end
        repeat (8) @(posedge sclkn);
        #1;
        got = {o_mosi, o_csn, o_sck, o_busy, o_done, o_re};
        checks++;
        if (got !== {5'b11001, 16'h003C}) begin
            errors++;
            $display("FAIL busy_start E17: got %h want %h",
                     got, {5'b11001, 16'h003C});
        end
        @(posedge sclkn);
        #1;
    endtask

    task automatic test_reset_mid();
        logic [20:0] got;
        int          bad;
        sel        = 0;
        loopb      = 1'b1;
        dse        = 16'h00A7;
        start_v[0] = 1'b1;
        @(posedge sclkn);
        #1;
        start_v[0] = 1'b0;
        repeat (3) @(posedge sclkn);
        #2;
        reset = 1'b1;
        #1;
        got = {o_mosi, o_csn, o_sck, o_busy, o_done, o_re};
        checks++;
        if (got !== {5'b11000, 16'h0000}) begin
            errors++;
            $display("FAIL reset_mid: got %h want %h",
                     got, {5'b11000, 16'h0000});
        end
        #4;
        reset = 1'b0;
        bad   = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge sclkn);
            #1;
            if ({o_csn, o_busy, o_done} !== 3'b100) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_mid quiet: got %0d bad cycles want 0", bad);
        end
        run_xfer(0, 16'($urandom), 1'b1, 16'h0000, "after_reset");
    endtask

    task automatic test_width16();
        run_xfer(2, 16'hA55A, 1'b1, 16'h0000, "w16_a55a");
        checks++;
        if (o_re !== 16'hA55A) begin
            errors++;
            $display("FAIL w16_a55a word: got %h want a55a", o_re);
        end
        run_xfer(2, 16'($urandom), 1'b0, 16'($urandom), "w16_miso");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            int s;
            s = int'($urandom_range(2, 0));
            run_xfer(s, 16'($urandom), 1'($urandom),
                     16'($urandom), "b2b");
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        sel      = 0;
        start_v  = 3'b000;
        dse      = 16'h0000;
        loopb    = 1'b1;
        miso_drv = 1'b0;
        reset    = 1'b1;
        test_reset();
        test_msb_loopback();
        test_lsb_loopback();
        test_miso();
        test_start_busy();
        test_reset_mid();
        test_width16();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
